ram_input_reader: RTL and testbench

//  Downstream consumer of the 1-bit-wide, 1024-deep input RAM. On a start pulse it reads LEN consecutive bits,

---
 rtl/ram_input_reader.sv | 136 +++++++++++++
 tb/tb_ram_input_reader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ram_input_reader.sv
// Streams LEN bits from a 1-bit RAM with one-cycle read latency and packs them LSB-first
// into OUT_WIDTH-bit words on a valid/ready output with full backpressure.
module ram_input_reader #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(OUT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t               state;
  logic [LW-1:0]        len_r;
  logic [LW-1:0]        issued_cnt;
  logic [LW-1:0]        recv_cnt;
  logic [CW-1:0]        acc_cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic                 in_flight;

  logic [OUT_WIDTH-1:0] acc_next;
  logic [CW-1:0]        cnt_next;
  logic [LW-1:0]        recv_next;
  logic                 word_ready;
  logic                 out_free;
  logic                 moves;
  logic                 issue;
  logic                 start_ok;

  // Accumulator view that already includes the bit returning this cycle.
  always_comb begin
    acc_next  = acc;
    cnt_next  = acc_cnt;
    recv_next = recv_cnt;
    if (in_flight) begin
      acc_next  = acc | (OUT_WIDTH'(ram_q[0]) << acc_cnt);
      cnt_next  = acc_cnt + CW'(1);
      recv_next = recv_cnt + LW'(1);
    end
    word_ready = (cnt_next == CW'(OUT_WIDTH)) || ((recv_next == len_r) && (cnt_next != '0));
    out_free   = !out_valid || out_ready;
    moves      = word_ready && out_free;
    // Never let more bits be outstanding than the accumulator can absorb.
    issue      = (state == READ) && (issued_cnt != len_r) &&
                 ((({1'b0, acc_cnt} + (CW+1)'(in_flight)) < (CW+1)'(OUT_WIDTH)) ||
                  (in_flight && moves));
    start_ok   = start && ((state == IDLE) || (state == FIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_r      <= '0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
      in_flight  <= 1'b0;
      ram_addr   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (moves) begin
        out_data  <= acc_next;
        out_valid <= 1'b1;
        out_last  <= (recv_next == len_r);
        acc       <= '0;
        acc_cnt   <= '0;
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        acc     <= acc_next;
        acc_cnt <= cnt_next;
      end

      recv_cnt  <= recv_next;
      in_flight <= issue;
      if (issue) begin
        ram_addr   <= ram_addr + ADDR_WIDTH'(1);
        issued_cnt <= issued_cnt + LW'(1);
      end

      case (state)
        IDLE, FIN: begin
          if (start_ok) begin
            len_r      <= len;
            ram_addr   <= base_addr;
            issued_cnt <= '0;
            recv_cnt   <= '0;
            if (len != '0) begin
              state <= READ;
              busy  <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (issue && ((issued_cnt + LW'(1)) == len_r)) state <= DRAIN;
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_input_reader.sv
// Randomized bench for ram_input_reader: RAM model, word scoreboard built from RAM contents,
// handshake stability and full-rate timing checks.
module tb_ram_input_reader;
  localparam int AW = 10;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] ram_addr;
  logic [0:0]    ram_q;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic mem [0:1023];
  int tests = 0;
  int fails = 0;

  ram_input_reader #(.DATA_WIDTH(1), .ADDR_WIDTH(AW), .OUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .ram_addr(ram_addr), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q[0] <= mem[ram_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: out_ready always 1 (timing checked), 1: random ready, 2: 20-cycle stall at first valid
  task automatic run_xfer(input int b, input int n, input int mode, input bit inject);
    logic [W-1:0]  exp_d[$];
    logic          exp_l[$];
    logic [W-1:0]  wd;
    logic [W-1:0]  pd;
    logic [AW-1:0] pa;
    logic          pv, pr;
    int nw, cyc, stall_left, first_v;
    bit fin;
    nw = (n + W - 1) / W;
    for (int i = 0; i < nw; i++) begin
      wd = '0;
      for (int j = 0; j < W; j++)
        if (i * W + j < n) wd[j] = mem[(b + i * W + j) % 1024];
      exp_d.push_back(wd);
      exp_l.push_back(i == nw - 1);
    end
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(n); out_ready = 1'b1;
    cyc = 0; stall_left = 0; first_v = -1; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = inject && (cyc == 50);
      if (start) begin
        base_addr = AW'($urandom);
        len = (AW+1)'($urandom_range(1, 64));
      end
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (out_valid && first_v < 0) stall_left = 20;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else out_ready = 1'b1;
      end
      if (cyc == 1 && n > 0) check("busy_on", busy, 1);
      if (mode == 0 && cyc <= n) check("addr_seq", ram_addr, (b + cyc - 1) % 1024);
      if (mode == 2 && stall_left > 0 && stall_left < 10) check("addr_frozen", ram_addr, pa);
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        if (mode == 0) check("first_valid_cyc", cyc, (n >= W) ? W + 2 : n + 2);
      end
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) check("extra_word", 1, 0);
        else begin
          check("word", out_data, exp_d.pop_front());
          check("last", out_last, exp_l.pop_front());
        end
      end
      if (done) begin
        fin = 1'b1;
        check("words_left", exp_d.size(), 0);
        check("busy_off", busy, 0);
        if (mode == 0) check("done_cyc", cyc, (n == 0) ? 1 : n + 3);
      end
      if (cyc > 6000) begin
        check("timeout", 0, 1);
        fin = 1'b1;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pa = ram_addr;
    end
  endtask

  initial begin
    logic [15:0] pat;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {ram_addr, out_data, out_valid, out_last, busy, done}, 0);
    rst = 1'b0;

    // mid-stream reset, then a clean transfer
    @(negedge clk); start = 1'b1; base_addr = '0; len = 11'd64;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid1", {ram_addr, out_data, out_valid, out_last, busy, done}, 0);
    @(negedge clk);
    check("rst_mid2", {ram_addr, out_data, out_valid, out_last, busy, done}, 0);
    rst = 1'b0;
    run_xfer(0, 8, 0, 1'b0);

    pat = 16'h3CA5;
    for (int i = 0; i < 16; i++) mem[i] = pat[i];
    run_xfer(0, 16, 0, 1'b0);

    for (int i = 0; i < 5; i++) mem[i] = 1'b1;
    run_xfer(0, 5, 0, 1'b0);
    run_xfer(0, 0, 0, 1'b0);

    for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom);
    run_xfer(int'($urandom_range(0, 1023)), 32, 2, 1'b0);
    run_xfer(1020, 8, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(1, 100)), 1, 1'b0);
    run_xfer(int'($urandom_range(0, 1023)), 1024, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
